sparse_coproc_stream: RTL and testbench

//  Parametrised successor of the coprocessor comm/memory path. Packs received bytes into

---
 rtl/sparse_coproc_stream.sv | 261 ++++++++++++++++++++++++++
 tb/tb_sparse_coproc_stream.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_coproc_stream.sv
// Byte-to-word packer, word FIFO and byte serialiser between the UART byte layer and the sparse FPU.
// Optional per-word XOR checksum byte on both directions when SPARSE_CHECKSUM_EN is defined.
module sparse_coproc_stream #(
    parameter int  WORD_BYTES = 17,
    parameter int  DEPTH      = 16,
    localparam int DATA_W     = 8 * WORD_BYTES,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              fpu_complete,
    output logic              tx_valid,
    output logic [7:0]        tx_byte,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] rd_word,
    output logic              rd_valid,
    output logic [CW-1:0]     count,
    output logic              busy,
    output logic              overflow,
    output logic              pop_drop,
    output logic              crc_err
);

`ifdef SPARSE_CHECKSUM_EN
    localparam int FRAME = WORD_BYTES + 1;
    localparam int RXW   = DATA_W;
`else
    localparam int FRAME = WORD_BYTES;
    localparam int RXW   = DATA_W - 8;
`endif
    localparam int IW = $clog2(FRAME);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(WORD_BYTES);

`ifdef SPARSE_CHECKSUM_EN
    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_CSUM} tx_state_t;
`else
    typedef enum logic [1:0] {TX_IDLE, TX_SEND} tx_state_t;
`endif

    tx_state_t         state;
    logic [IW-1:0]     rx_idx;
    logic [RXW-1:0]    rx_word;
    logic [RXW+7:0]    rx_cat;
    logic              word_done;
    logic              word_ok;
    logic [DATA_W-1:0] push_word;
    logic              push;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;

    logic              fd_q;
    logic              pop_req;
    logic              pending;
    logic              tx_idle;
    logic              do_pop;
    logic              set_pending;
    logic              clr_pending;
    logic              drop;

    logic [DATA_W-1:0] tx_shift;
    logic [LW-1:0]     tx_left;

    // Bytes enter at the top and shift down, so byte0 ends up in bits [7:0] once the word is full.
    assign rx_cat     = {rx_byte, rx_word};
    assign fifo_full  = (count == CW'(DEPTH));
    assign fifo_empty = (count == '0);
    assign head       = mem[rd_ptr];
    assign pop_req    = fd_q & ~fpu_complete;
    assign tx_idle    = (state == TX_IDLE);
    assign busy       = ~tx_idle | pending;
    assign push       = word_done & word_ok & ~fifo_full;

`ifdef SPARSE_CHECKSUM_EN
    logic [7:0] rx_xor;
    logic [7:0] tx_csum;

    function automatic logic [7:0] xor_bytes(input logic [DATA_W-1:0] w);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            x = x ^ w[i*8 +: 8];
        end
        return x;
    endfunction

    assign word_done = rx_valid && (rx_idx == IW'(WORD_BYTES));
    assign word_ok   = (rx_byte == rx_xor);
    assign push_word = rx_word;
`else
    assign word_done = rx_valid && (rx_idx == IW'(WORD_BYTES - 1));
    assign word_ok   = 1'b1;
    assign push_word = rx_cat;
    assign crc_err   = 1'b0;
`endif

    // RX packer: byte index always wraps at frame end, whether or not the word is kept.
    always_ff @(posedge clk) begin
        if (resetn) begin
            rx_idx   <= '0;
            rx_word  <= '0;
            overflow <= 1'b0;
`ifdef SPARSE_CHECKSUM_EN
            rx_xor   <= '0;
            crc_err  <= 1'b0;
`endif
        end else if (rx_valid) begin
            if (rx_idx == IW'(FRAME - 1)) begin
                rx_idx <= '0;
            end else begin
                rx_idx <= rx_idx + 1'b1;
            end
`ifdef SPARSE_CHECKSUM_EN
            if (word_done) begin
                rx_xor <= '0;
                if (!word_ok) begin
                    crc_err <= 1'b1;
                end
            end else begin
                rx_word <= rx_cat[RXW+7:8];
                rx_xor  <= rx_xor ^ rx_byte;
            end
`else
            rx_word <= rx_cat[RXW+7:8];
`endif
            if (word_done && word_ok && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Pop arbitration: a waiting request is serviced first; a second request while one waits is lost.
    always_comb begin
        do_pop      = 1'b0;
        set_pending = 1'b0;
        clr_pending = 1'b0;
        drop        = 1'b0;
        if (tx_idle && pending) begin
            clr_pending = 1'b1;
            do_pop      = ~fifo_empty;
        end
        if (pop_req) begin
            if (pending || fifo_empty) begin
                drop = 1'b1;
            end else if (tx_idle) begin
                do_pop = 1'b1;
            end else begin
                set_pending = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fd_q     <= 1'b0;
            pending  <= 1'b0;
            pop_drop <= 1'b0;
        end else begin
            fd_q <= fpu_complete;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (set_pending) begin
                pending <= 1'b1;
            end else if (clr_pending) begin
                pending <= 1'b0;
            end
            if (drop) begin
                pop_drop <= 1'b1;
            end
        end
    end

    // TX serialiser: byte0 is presented in the cycle after the pop and held until accepted.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state    <= TX_IDLE;
            tx_valid <= 1'b0;
            tx_byte  <= '0;
            tx_shift <= '0;
            tx_left  <= '0;
            rd_word  <= '0;
            rd_valid <= 1'b0;
`ifdef SPARSE_CHECKSUM_EN
            tx_csum  <= '0;
`endif
        end else begin
            rd_valid <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (do_pop) begin
                        rd_word  <= head;
                        rd_valid <= 1'b1;
                        tx_valid <= 1'b1;
                        tx_byte  <= head[7:0];
                        tx_shift <= head >> 8;
                        tx_left  <= LW'(WORD_BYTES - 1);
`ifdef SPARSE_CHECKSUM_EN
                        tx_csum  <= xor_bytes(head);
`endif
                        state    <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (tx_ready) begin
                        if (tx_left == '0) begin
`ifdef SPARSE_CHECKSUM_EN
                            tx_byte  <= tx_csum;
                            state    <= TX_CSUM;
`else
                            tx_valid <= 1'b0;
                            state    <= TX_IDLE;
`endif
                        end else begin
                            tx_byte  <= tx_shift[7:0];
                            tx_shift <= tx_shift >> 8;
                            tx_left  <= tx_left - 1'b1;
                        end
                    end
                end
`ifdef SPARSE_CHECKSUM_EN
                TX_CSUM: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= TX_IDLE;
                    end
                end
`endif
                default: begin
                    tx_valid <= 1'b0;
                    state    <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_coproc_stream.sv
// Self-checking bench for sparse_coproc_stream (WORD_BYTES=2, DEPTH=4) against a queue-based word/byte model.
// Follows SPARSE_CHECKSUM_EN so the same bench covers both builds.
module tb_sparse_coproc_stream;

    localparam int WB    = 2;
    localparam int DEPTH = 4;
    localparam int DW    = 8 * WB;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic          fpu_complete;
    logic          tx_valid;
    logic [7:0]    tx_byte;
    logic          tx_ready;
    logic [DW-1:0] rd_word;
    logic          rd_valid;
    logic [CW-1:0] count;
    logic          busy;
    logic          overflow;
    logic          pop_drop;
    logic          crc_err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_q [$];
    logic [7:0]    exp_tx  [$];
    logic [7:0]    got_tx  [$];
    logic          ovf_m;
    logic          drop_m;
    logic          crc_m;

    sparse_coproc_stream #(.WORD_BYTES(WB), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .fpu_complete(fpu_complete), .tx_valid(tx_valid), .tx_byte(tx_byte),
        .tx_ready(tx_ready), .rd_word(rd_word), .rd_valid(rd_valid), .count(count),
        .busy(busy), .overflow(overflow), .pop_drop(pop_drop), .crc_err(crc_err)
    );

    always #5 clk = ~clk;

    // Consumer side: every handshake outside reset is one byte leaving the block.
    always @(posedge clk) begin
        if (!resetn && tx_valid && tx_ready) begin
            got_tx.push_back(tx_byte);
        end
    end

    function automatic logic [7:0] word_xor(input logic [DW-1:0] w);
        return w[7:0] ^ w[15:8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_flags(input string tag);
        checkOutput({tag, "_count"}, 32'(count), 32'(model_q.size()));
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'(ovf_m));
        checkOutput({tag, "_pop_drop"}, 32'(pop_drop), 32'(drop_m));
        checkOutput({tag, "_crc_err"}, 32'(crc_err), 32'(crc_m));
    endtask

    task automatic doReset();
        resetn       = 1'b1;
        rx_valid     = 1'b0;
        rx_byte      = '0;
        fpu_complete = 1'b0;
        tx_ready     = 1'b0;
        tick();
        tick();
        model_q.delete();
        exp_tx.delete();
        got_tx.delete();
        ovf_m  = 1'b0;
        drop_m = 1'b0;
        crc_m  = 1'b0;
        checkOutput("rst_tx_valid", 32'(tx_valid), 0);
        checkOutput("rst_tx_byte", 32'(tx_byte), 0);
        checkOutput("rst_rd_word", 32'(rd_word), 0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        check_flags("rst");
        resetn = 1'b0;
    endtask

    // Sends one word LSB-first; csum is the trailing check byte in checksum builds.
    task automatic applyStimulus(input logic [DW-1:0] w, input logic [7:0] csum);
        logic good;
        for (int b = 0; b < WB; b++) begin
            rx_valid = 1'b1;
            rx_byte  = w[b*8 +: 8];
            tick();
        end
        good = 1'b1;
`ifdef SPARSE_CHECKSUM_EN
        rx_valid = 1'b1;
        rx_byte  = csum;
        tick();
        good = (csum == word_xor(w));
`endif
        rx_valid = 1'b0;
        rx_byte  = '0;
        if (!good) begin
            crc_m = 1'b1;
        end else if (model_q.size() < DEPTH) begin
            model_q.push_back(w);
        end else begin
            ovf_m = 1'b1;
        end
    endtask

    task automatic fall_pulse();
        fpu_complete = 1'b1;
        tick();
        fpu_complete = 1'b0;
        tick();
    endtask

    // Expected outcome of a request issued while the transmitter is idle and nothing waits.
    task automatic model_pop(input string tag);
        logic [DW-1:0] w;
        if (model_q.size() > 0) begin
            w = model_q.pop_front();
            for (int b = 0; b < WB; b++) exp_tx.push_back(w[b*8 +: 8]);
`ifdef SPARSE_CHECKSUM_EN
            exp_tx.push_back(word_xor(w));
`endif
            checkOutput({tag, "_rd_valid"}, 32'(rd_valid), 1);
            checkOutput({tag, "_rd_word"}, 32'(rd_word), 32'(w));
            checkOutput({tag, "_tx_valid"}, 32'(tx_valid), 1);
            checkOutput({tag, "_tx_byte0"}, 32'(tx_byte), 32'(w[7:0]));
        end else begin
            drop_m = 1'b1;
            checkOutput({tag, "_rd_valid"}, 32'(rd_valid), 0);
            checkOutput({tag, "_tx_valid"}, 32'(tx_valid), 0);
        end
    endtask

    task automatic drain_tx(input bit random_ready);
        for (int i = 0; i < 300; i++) begin
            tx_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (!busy && !tx_valid) break;
        end
        tx_ready = 1'b0;
        checkOutput("drain_idle", 32'(busy | tx_valid), 0);
    endtask

    task automatic compare_tx(input string tag);
        checkOutput({tag, "_tx_len"}, 32'(got_tx.size()), 32'(exp_tx.size()));
        for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++) begin
            checkOutput({tag, "_tx_data"}, 32'(got_tx[i]), 32'(exp_tx[i]));
        end
        got_tx.delete();
        exp_tx.delete();
    endtask

    initial begin
        logic [DW-1:0] w;
        logic [DW-1:0] wa;
        logic [DW-1:0] wb;
        logic [7:0]    held;
        int            n;

        // Single word round trip.
        doReset();
        applyStimulus(16'h1234, 8'h26);
        check_flags("t1_push");
        fall_pulse();
        model_pop("t1");
        tick();
        checkOutput("t1_rd_valid_pulse", 32'(rd_valid), 0);
        drain_tx(1'b0);
        compare_tx("t1");
        checkOutput("t1_rd_word_held", 32'(rd_word), 32'h1234);

        // Overflow: fifth word dropped, four drain in order.
        doReset();
        for (int k = 0; k < 5; k++) begin
            w = DW'(16'h1100 + 16'h0101 * k);
            applyStimulus(w, word_xor(w));
        end
        check_flags("t2_full");
        for (int k = 0; k < 4; k++) begin
            fall_pulse();
            model_pop("t2");
            drain_tx(1'b0);
        end
        check_flags("t2_empty");
        compare_tx("t2");

        // Pending request while busy, then a lost request.
        doReset();
        wa = 16'hBEEF;
        wb = 16'hCAFE;
        applyStimulus(wa, word_xor(wa));
        applyStimulus(wb, word_xor(wb));
        fall_pulse();
        model_pop("t3a");
        held = tx_byte;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("t3_tx_hold", 32'(tx_byte), 32'(held));
        end
        fall_pulse();
        checkOutput("t3_busy", 32'(busy), 1);
        checkOutput("t3_no_pop", 32'(rd_valid), 0);
        check_flags("t3_pending");
        fall_pulse();
        drop_m = 1'b1;
        check_flags("t3_drop");
        void'(model_q.pop_front());
        for (int b = 0; b < WB; b++) exp_tx.push_back(wb[b*8 +: 8]);
`ifdef SPARSE_CHECKSUM_EN
        exp_tx.push_back(word_xor(wb));
`endif
        drain_tx(1'b0);
        checkOutput("t3_rd_word", 32'(rd_word), 32'(wb));
        check_flags("t3_end");
        compare_tx("t3");

        // Request on an empty FIFO.
        doReset();
        fall_pulse();
        model_pop("t4");
        tick();
        checkOutput("t4_tx_valid", 32'(tx_valid), 0);
        check_flags("t4");

        // Reset in the middle of a transfer.
        doReset();
        for (int k = 0; k < 5; k++) begin
            w = DW'($urandom);
            applyStimulus(w, word_xor(w));
        end
        fall_pulse();
        model_pop("t5");
        tx_ready = 1'b1;
        tick();
        resetn = 1'b1;
        tick();
        checkOutput("t5_tx_valid", 32'(tx_valid), 0);
        checkOutput("t5_count", 32'(count), 0);
        checkOutput("t5_overflow", 32'(overflow), 0);
        checkOutput("t5_busy", 32'(busy), 0);
        resetn = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        checkOutput("t5_tx_len", 32'(got_tx.size()), 1);
        checkOutput("t5_tx_byte0", 32'(got_tx.size() > 0 ? got_tx[0] : 8'hxx), 32'(exp_tx[0]));
        tx_ready = 1'b0;

        // A partial RX word is forgotten across reset.
        doReset();
        rx_valid = 1'b1;
        rx_byte  = 8'hAA;
        tick();
        doReset();
        applyStimulus(16'h5678, 8'h2E);
        fall_pulse();
        model_pop("partial");
        drain_tx(1'b0);
        compare_tx("partial");

`ifdef SPARSE_CHECKSUM_EN
        // Checksum accept and reject.
        doReset();
        applyStimulus(16'h1234, 8'h26);
        applyStimulus(16'h1234, 8'h00);
        check_flags("t6");
        fall_pulse();
        model_pop("t6");
        drain_tx(1'b0);
        compare_tx("t6");
`endif

        // Random words, random fill level, random consumer stalls.
        for (int it = 0; it < 8; it++) begin
            doReset();
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                w = DW'($urandom);
                applyStimulus(w, ($urandom_range(0, 7) == 0) ? ~word_xor(w) : word_xor(w));
            end
            check_flags("rnd_fill");
            for (int k = 0; k <= n; k++) begin
                fall_pulse();
                model_pop("rnd");
                drain_tx(1'b1);
            end
            check_flags("rnd_end");
            compare_tx("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
